// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with count, sticky errors and flush
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through read mode;
// when undefined, rd_data/rd_valid are registered one cycle after each pop.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic              ov_set;
  logic              uf_set;

  // Status flags decode only from the registered count, never from requests.
  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A flush cycle swallows both requests and cannot raise an error.
  assign rd_acc = rd_en && !empty && !flush;
  assign wr_acc = wr_en && (!full || rd_acc) && !flush;
  assign ov_set = wr_en && !wr_acc && !flush;
  assign uf_set = rd_en && empty && !flush;

  // Storage array: written on every accepted write, never reset or cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky error flags; a set event beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + CW'(1);
        end
        if (rd_acc) begin
          rd_ptr <= rd_ptr + CW'(1);
        end
        if (wr_acc && !rd_acc) begin
          count <= count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
          count <= count - CW'(1);
        end
      end
      overflow  <= ov_set || (overflow && !err_clr);
      underflow <= uf_set || (underflow && !err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented straight from the array; rd_en acknowledges it.
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
  // Registered read: popped word and its valid strobe appear one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (vectors, sequences, random vs queue model)
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = DP - 2;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue of stored words plus sticky bits.
  logic [DW-1:0] mq[$];
  bit            m_ov, m_uf, m_rv;
  logic [DW-1:0] m_rd;

  typedef struct {
    logic          wr, rd;
    logic [DW-1:0] d;
    int            cnt;
    logic          fu, em, af, ov, uf, rv;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t tv [34];

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input logic wr, input logic rd, input int d, input int cnt,
                              input logic ov, input logic uf, input logic rv, input int rdat);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d = DW'(d); v.cnt = cnt;
    v.fu = (cnt == DP); v.em = (cnt == 0); v.af = (cnt >= AF);
    v.ov = ov; v.uf = uf; v.rv = rv; v.rdat = DW'(rdat);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_uf = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic f, input logic e,
                            input logic [DW-1:0] d);
    bit was_full, was_empty, racc, wacc, oset, uset;
    logic [DW-1:0] popped;
    popped = '0;
    if (f) begin
      mq.delete();
      m_rv = 0;
      if (e) begin m_ov = 0; m_uf = 0; end
      return;
    end
    was_full  = (mq.size() == DP);
    was_empty = (mq.size() == 0);
    racc = r && !was_empty;
    wacc = w && (!was_full || racc);
    oset = w && !wacc;
    uset = r && was_empty;
    if (racc) popped = mq.pop_front();
    if (wacc) mq.push_back(d);
    m_rv = racc;
    if (racc) m_rd = popped;
    m_ov = oset || (m_ov && !e);
    m_uf = uset || (m_uf && !e);
  endtask

  task automatic compare_model();
    int n;
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DP));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_uf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd_valid", 32'(rd_valid), 32'(n != 0));
    if (n != 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
`else
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
`endif
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic e,
                      input logic [DW-1:0] d);
    wr_en = w; rd_en = r; flush = f; err_clr = e; wr_data = d;
    @(posedge clk);
    #1;
    model_step(w, r, f, e, d);
    compare_model();
  endtask

  initial begin
    // Vector table: fill to full, overflow, drain in order, underflow.
    for (int i = 0; i < 16; i++) tv[i] = mk(1, 0, i, i + 1, 0, 0, 0, 0);
    tv[16] = mk(1, 0, 8'hEE, 16, 1, 0, 0, 0);
    for (int j = 0; j < 16; j++) tv[17 + j] = mk(0, 1, 0, 15 - j, 1, 0, 1, j);
    tv[33] = mk(0, 1, 0, 0, 1, 1, 0, 0);

    rst = 1; flush = 0; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    rst = 0;

    for (int k = 0; k < 34; k++) begin
      step(tv[k].wr, tv[k].rd, 1'b0, 1'b0, tv[k].d);
      chk("tv_count", 32'(count), 32'(tv[k].cnt));
      chk("tv_full", 32'(full), 32'(tv[k].fu));
      chk("tv_empty", 32'(empty), 32'(tv[k].em));
      chk("tv_almost_full", 32'(almost_full), 32'(tv[k].af));
      chk("tv_overflow", 32'(overflow), 32'(tv[k].ov));
      chk("tv_underflow", 32'(underflow), 32'(tv[k].uf));
`ifndef SYNC_FIFO_FWFT_EN
      chk("tv_rd_valid", 32'(rd_valid), 32'(tv[k].rv));
      if (tv[k].rv) chk("tv_rd_data", 32'(rd_data), 32'(tv[k].rdat));
`endif
    end

    // Clear errors, then steady-state wrap with 4 words in flight.
    step(0, 0, 0, 1, 0);
    chk("errclr_ov", 32'(overflow), 0);
    chk("errclr_uf", 32'(underflow), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, DW'(8'h10 + i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, DW'(8'h14 + i));
      chk("wrap_count", 32'(count), 4);
      chk("wrap_errs", 32'({overflow, underflow}), 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("wrap_data", 32'(rd_data), 32'(8'h10 + i));
`else
      chk("wrap_head", 32'(rd_data), 32'(8'h11 + i));
`endif
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);

    // Full with simultaneous read and write.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, DW'(8'h30 + i));
    step(1, 1, 0, 0, 8'hAA);
    chk("fullrw_count", 32'(count), 16);
    chk("fullrw_ov", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
      if (i == 15) chk("fullrw_aa_out", 32'(rd_data), 32'h0AA);
`else
      if (i == 14) chk("fullrw_aa_head", 32'(rd_data), 32'h0AA);
`endif
    end

    // Empty with simultaneous read and write.
    step(1, 1, 0, 0, 8'h77);
    chk("emptyrw_count", 32'(count), 1);
    chk("emptyrw_uf", 32'(underflow), 1);
    step(0, 1, 0, 1, 0);

    // Flush at count 9 with both sticky flags set and requests asserted.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, DW'(8'h50 + i));
    step(1, 0, 0, 0, 8'hFF);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 8'h61);
    step(0, 0, 0, 0, 0);
    wr_en = 0; rd_en = 0;
    mq.delete(); // reach an empty FIFO then underflow; rebuild count 9
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, DW'(8'h80 + i));
    step(1, 0, 0, 0, 8'hFE);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    chk("preflush_count", 32'(count), 9);
    chk("preflush_flags", 32'({overflow, underflow}), 3);
    step(1, 1, 1, 0, 8'h99);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_rd_valid", 32'(rd_valid), 0);
    chk("flush_flags", 32'({overflow, underflow}), 3);
    step(0, 0, 0, 1, 0);
    chk("clr_flags", 32'({overflow, underflow}), 0);

`ifdef SYNC_FIFO_FWFT_EN
    step(1, 0, 0, 0, 8'h5A);
    chk("fwft_valid", 32'(rd_valid), 1);
    chk("fwft_data", 32'(rd_data), 32'h05A);
    step(0, 0, 0, 0, 0);
    chk("fwft_hold", 32'(rd_valid), 1);
    step(0, 1, 0, 0, 0);
    chk("fwft_pop_valid", 32'(rd_valid), 0);
    chk("fwft_pop_empty", 32'(empty), 1);
`endif

    // Randomised traffic with shifting write/read bias against the model.
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 25 : 55);
      rp = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 80 : 55);
      for (int c = 0; c < 300; c++) begin
        step(($urandom_range(99) < wp), ($urandom_range(99) < rp),
             ($urandom_range(127) == 0), ($urandom_range(31) == 0), DW'($urandom));
      end
    end

    // Asynchronous reset mid-cycle clears state without waiting for an edge.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, DW'(i));
    step(0, 1, 0, 0, 0);
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_rd_valid", 32'(rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("arst_rd_data", 32'(rd_data), 0);
`endif
    @(posedge clk);
    #1 rst = 0;
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
